glip_bus_responder: RTL and testbench



---
 rtl/glip_bus_responder_pkg.sv | 27 ++
 rtl/glip_out_reg.sv | 38 +++
 rtl/glip_bus_responder.sv | 203 ++++++++++++++++++++
 tb/tb_glip_bus_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/glip_bus_responder_pkg.sv
// glip_bus_responder_pkg: shared states, header fields and response codes for the GLIP bus responder
package glip_bus_responder_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_WR_DATA,
        S_WR_BUS,
        S_WR_RESP,
        S_RD_HDR,
        S_RD_BUS,
        S_RD_DATA,
        S_ERR_RESP
    } state_e;

    localparam int          OPC_BIT  = 15;
    localparam logic [15:0] RSV_MASK = 16'h7F00;
    localparam logic [15:0] RSP_RD   = 16'h8000;
    localparam logic [15:0] RSP_WR   = 16'hC000;
    localparam logic [15:0] RSP_ERR  = 16'hE000;
    localparam logic [15:0] TMO_FILL = 16'hDEAD;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/glip_out_reg.sv
// glip_out_reg: one-entry output holding register; word and valid stay put until the sink takes them
module glip_out_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk_logic,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_valid_i,
    input  logic [15:0]      push_data_i,
    output logic             push_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i
);

    logic        valid_q, valid_d;
    logic [15:0] data_q, data_d;

    assign push_ready_o = !valid_q || out_ready_i;
    assign out_valid_o  = valid_q;
    assign out_data_o   = WIDTH'(data_q);

    always_comb begin
        valid_d = flush_i ? 1'b0 : push_ready_o ? push_valid_i : valid_q;
        data_d  = (push_ready_o && push_valid_i) ? push_data_i : data_q;
    end

    always_ff @(posedge clk_logic or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= 16'h0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/glip_bus_responder.sv
// glip_bus_responder: turns GLIP command words into req/ack register bursts and streams back responses
module glip_bus_responder
    import glip_bus_responder_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_logic,
    input  logic             rst_n,
    input  logic             logic_rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             bus_req,
    output logic             bus_we,
    output logic [15:0]      bus_addr,
    output logic [15:0]      bus_wdata,
    input  logic             bus_ack,
    input  logic [15:0]      bus_rdata,
    output logic             busy,
    output logic [7:0]       err_count
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        live_q;
    logic        w_q, w_d;
    logic        req_q, req_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  beat_q, beat_d;
    logic [7:0]  err_q, err_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] tmo_q, tmo_d;
    logic        push_valid, push_ready;
    logic [15:0] push_data;
    logic [15:0] word;
    logic        hit, expire, done, err_inc;
    logic        unused_in;

    assign word      = in_data[15:0];
    assign unused_in = ^(in_data >> 16);
    // An ack landing on the last allowed cycle wins over the timeout.
    assign hit       = req_q && bus_ack;
    assign expire    = req_q && !bus_ack && (tmo_q == TMO_LAST);
    assign done      = hit || expire;

    assign bus_req   = req_q;
    assign bus_we    = req_q && w_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign busy      = state_q != S_IDLE;
    assign err_count = err_q;

    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        len_d      = len_q;
        beat_d     = beat_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        req_d      = req_q;
        tmo_d      = tmo_q;
        in_ready   = 1'b0;
        push_valid = 1'b0;
        push_data  = 16'h0;
        err_inc    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                in_ready = live_q;
                if (in_valid && live_q) begin
                    w_d     = word[OPC_BIT];
                    len_d   = word[7:0];
                    err_inc = |(word & RSV_MASK);
                    state_d = err_inc ? S_ERR_RESP : S_ADDR;
                end
            end
            S_ADDR: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    addr_d  = word;
                    beat_d  = len_q;
                    state_d = w_q ? S_WR_DATA : S_RD_HDR;
                end
            end
            S_WR_DATA: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wdata_d = word;
                    req_d   = 1'b1;
                    tmo_d   = 16'h0;
                    state_d = S_WR_BUS;
                end
            end
            S_WR_BUS: begin
                tmo_d = done ? tmo_q : tmo_q + 16'h1;
                if (done) begin
                    req_d   = 1'b0;
                    err_inc = expire;
                    addr_d  = (beat_q != 8'h0) ? addr_q + 16'h1 : addr_q;
                    beat_d  = (beat_q != 8'h0) ? beat_q - 8'h1 : beat_q;
                    state_d = (beat_q != 8'h0) ? S_WR_DATA : S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                push_valid = 1'b1;
                push_data  = RSP_WR | {8'h0, len_q};
                state_d    = push_ready ? S_IDLE : S_WR_RESP;
            end
            S_RD_HDR: begin
                push_valid = 1'b1;
                push_data  = RSP_RD | {8'h0, len_q};
                if (push_ready) begin
                    req_d   = 1'b1;
                    tmo_d   = 16'h0;
                    state_d = S_RD_BUS;
                end
            end
            S_RD_BUS: begin
                tmo_d = done ? tmo_q : tmo_q + 16'h1;
                if (done) begin
                    req_d   = 1'b0;
                    err_inc = expire;
                    rdata_d = hit ? bus_rdata : TMO_FILL;
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                push_valid = 1'b1;
                push_data  = rdata_q;
                if (push_ready) begin
                    req_d   = beat_q != 8'h0;
                    tmo_d   = 16'h0;
                    addr_d  = (beat_q != 8'h0) ? addr_q + 16'h1 : addr_q;
                    beat_d  = (beat_q != 8'h0) ? beat_q - 8'h1 : beat_q;
                    state_d = (beat_q != 8'h0) ? S_RD_BUS : S_IDLE;
                end
            end
            S_ERR_RESP: begin
                push_valid = 1'b1;
                push_data  = RSP_ERR | {8'h0, len_q};
                state_d    = push_ready ? S_IDLE : S_ERR_RESP;
            end
            default: state_d = S_IDLE;
        endcase
        err_d = err_inc ? sat_inc(err_q) : err_q;
        // Flush abandons the transaction but keeps the error history.
        if (logic_rst) begin
            state_d = S_IDLE;
            req_d   = 1'b0;
            tmo_d   = 16'h0;
            beat_d  = 8'h0;
            err_d   = err_q;
        end
    end

    always_ff @(posedge clk_logic or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            live_q  <= 1'b0;
            w_q     <= 1'b0;
            req_q   <= 1'b0;
            len_q   <= 8'h0;
            beat_q  <= 8'h0;
            err_q   <= 8'h0;
            addr_q  <= 16'h0;
            wdata_q <= 16'h0;
            rdata_q <= 16'h0;
            tmo_q   <= 16'h0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            w_q     <= w_d;
            req_q   <= req_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
        end
    end

    glip_out_reg #(.WIDTH(WIDTH)) u_out (
        .clk_logic   (clk_logic),
        .rst_n       (rst_n),
        .flush_i     (logic_rst),
        .push_valid_i(push_valid),
        .push_data_i (push_data),
        .push_ready_o(push_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ready_i (out_ready)
    );

endmodule

// File: tb/tb_glip_bus_responder.sv
// tb_glip_bus_responder: randomized scoreboard bench with a bus slave model and an output monitor
module tb_glip_bus_responder;

    localparam int W     = 32;
    localparam int TMO   = 4;
    localparam int NOACK = -1;

    typedef struct {
        bit        we;
        bit [15:0] addr;
        bit [15:0] wd;
        int        lat;
    } beat_t;

    logic          clk = 0, rst_n = 1, logic_rst = 0;
    logic [W-1:0]  in_data = '0, out_data;
    logic          in_valid = 0, in_ready, out_valid, out_ready = 0;
    logic          bus_req, bus_we, bus_ack, slave_ack = 0, stray_ack = 0, busy;
    logic [15:0]   bus_addr, bus_wdata, bus_rdata = 16'h0;
    logic [7:0]    err_count;

    beat_t         exp_bus[$];
    logic [15:0]   exp_out[$];
    bit [15:0]     ref_mem[int];
    bit [15:0]     bus_mem[int];
    int            total = 0, bad = 0, mdl_err = 0, rdy_mode = 0;
    bit            flushing = 0;

    assign bus_ack = slave_ack | stray_ack;

    initial forever #5 clk = ~clk;

    glip_bus_responder #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk_logic(clk), .rst_n(rst_n), .logic_rst(logic_rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .busy(busy), .err_count(err_count)
    );

    function automatic bit [15:0] init_val(input int a);
        return 16'(a) ^ 16'hA5C3;
    endfunction

    task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        bad++;
        $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) fail(name, act, exp);
        else total++;
    endtask

    task automatic err_bump();
        mdl_err = (mdl_err < 255) ? mdl_err + 1 : 255;
    endtask

    // Output monitor: owns out_ready, checks holding and pops the scoreboard on each transfer.
    initial begin
        logic [W-1:0] held;
        bit pend;
        pend = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (pend) begin
                chk("out_hold_valid", out_valid, 1);
                chk("out_hold_data", out_data, held);
            end
            out_ready = (rdy_mode == 0) ? ($urandom_range(0, 3) != 0) :
                        (rdy_mode == 1) ? ~out_ready : 1'b1;
            pend = 0;
            if (out_valid && rst_n) begin
                if (!out_ready) begin
                    pend = 1;
                    held = out_data;
                end else if (exp_out.size() == 0) fail("out_unexpected", out_data, 0);
                else chk("out_data", out_data, W'(exp_out.pop_front()));
            end
        end
    end

    // Bus slave: checks each beat against the scoreboard and acks after the planned latency.
    initial begin
        int cnt;
        bit acked, prev;
        beat_t b;
        cnt = 0; acked = 0; prev = 0;
        b = '{we: 1'b0, addr: 16'h0, wd: 16'h0, lat: NOACK};
        forever begin
            @(negedge clk);
            slave_ack = 0;
            if (!bus_req) begin
                if (prev && !acked && !flushing) chk("bus_tmo_len", cnt, TMO);
                cnt = 0;
                acked = 0;
            end else if (acked) fail("bus_req_after_ack", 1, 0);
            else begin
                if (cnt >= TMO) fail("bus_req_len", cnt, TMO - 1);
                if (cnt == 0) begin
                    if (exp_bus.size() == 0) begin
                        fail("bus_unexpected", bus_addr, 0);
                        b.lat = NOACK;
                    end else begin
                        b = exp_bus.pop_front();
                        chk("bus_we", bus_we, b.we);
                        chk("bus_addr", bus_addr, b.addr);
                        if (b.we) chk("bus_wdata", bus_wdata, b.wd);
                    end
                end else chk("bus_addr_hold", bus_addr, b.addr);
                if (cnt == b.lat) begin
                    slave_ack = 1;
                    acked = 1;
                    if (bus_we) bus_mem[int'(bus_addr)] = bus_wdata;
                    else bus_rdata = bus_mem.exists(int'(bus_addr)) ? bus_mem[int'(bus_addr)] : init_val(int'(bus_addr));
                end else bus_rdata = 16'($urandom);
                cnt++;
            end
            prev = bus_req;
        end
    end

    task automatic send(input logic [15:0] w);
        int t;
        t = 0;
        repeat ($urandom_range(0, 1)) @(negedge clk);
        @(negedge clk);
        in_data = {16'($urandom), w};
        in_valid = 1;
        while (!in_ready && t < 10000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) fail("in_handshake", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 0;
        in_data = W'($urandom);
    endtask

    // Reference model: expected bus beats and responses come straight from the command semantics.
    task automatic cmd(input bit w, input int n, input logic [15:0] a, input int to_pct,
                       input int fix_lat, input int dbase);
        logic [15:0] d[$];
        logic [15:0] ai, dv;
        int lat;
        if (!w) exp_out.push_back(16'h8000 | 16'(n - 1));
        for (int i = 0; i < n; i++) begin
            ai = a + 16'(i);
            lat = ($urandom_range(0, 99) < to_pct) ? NOACK :
                  (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, TMO - 1));
            if (lat == NOACK) err_bump();
            if (w) begin
                dv = (dbase < 0) ? 16'($urandom) : 16'(dbase + i);
                d.push_back(dv);
                exp_bus.push_back('{we: 1'b1, addr: ai, wd: dv, lat: lat});
                if (lat != NOACK) ref_mem[int'(ai)] = dv;
            end else begin
                exp_bus.push_back('{we: 1'b0, addr: ai, wd: 16'h0, lat: lat});
                exp_out.push_back((lat == NOACK) ? 16'hDEAD :
                                  ref_mem.exists(int'(ai)) ? ref_mem[int'(ai)] : init_val(int'(ai)));
            end
        end
        if (w) exp_out.push_back(16'hC000 | 16'(n - 1));
        send({w, 7'h0, 8'(n - 1)});
        send(a);
        foreach (d[i]) send(d[i]);
    endtask

    task automatic err_hdr(input logic [15:0] h);
        exp_out.push_back(16'hE000 | {8'h0, h[7:0]});
        err_bump();
        send(h);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(!busy && !out_valid && !bus_req && exp_out.size() == 0 && exp_bus.size() == 0) && t < 20000);
        if (t >= 20000) fail("idle_timeout", t, 0);
        chk("err_count", err_count, mdl_err);
    endtask

    initial begin
        logic [15:0] h;
        int r, n;
        #2 rst_n = 0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_count, 0);
        rst_n = 1;
        @(posedge clk);
        #1 chk("idle_in_ready", in_ready, 1);

        rdy_mode = 2;
        cmd(1, 1, 16'h0010, 0, 2, 16'h1234);
        wait_idle();
        cmd(1, 4, 16'hFFFE, 0, -1, 16'h00A0);
        wait_idle();
        cmd(0, 4, 16'hFFFE, 0, -1, 0);
        wait_idle();
        rdy_mode = 1;
        cmd(0, 4, 16'hFFFE, 0, -1, 0);
        wait_idle();
        rdy_mode = 0;
        cmd(0, 1, 16'h1234, 100, -1, 0);
        wait_idle();
        err_hdr(16'h0100);
        cmd(0, 1, 16'h0010, 0, -1, 0);
        wait_idle();

        flushing = 1;
        exp_bus.push_back('{we: 1'b1, addr: 16'h4000, wd: 16'h5555, lat: NOACK});
        send(16'h8003);
        send(16'h4000);
        send(16'h5555);
        chk("flush_pre_req", bus_req, 1);
        @(negedge clk);
        logic_rst = 1;
        @(posedge clk);
        #1 logic_rst = 0;
        chk("flush_busy", busy, 0);
        chk("flush_bus_req", bus_req, 0);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_err", err_count, mdl_err);
        @(negedge clk);
        stray_ack = 1;
        @(negedge clk);
        stray_ack = 0;
        repeat (3) @(negedge clk);
        chk("stray_busy", busy, 0);
        chk("stray_out_valid", out_valid, 0);
        chk("stray_err", err_count, mdl_err);
        flushing = 0;
        cmd(1, 2, 16'h4000, 0, -1, -1);
        cmd(0, 2, 16'h4000, 0, -1, 0);
        wait_idle();

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) err_hdr({1'($urandom), 7'($urandom_range(1, 127)), 8'($urandom)});
            else begin
                n = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 256) : $urandom_range(1, 8);
                h = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 4)) : 16'($urandom);
                cmd(r < 5, n, h, 10, -1, -1);
            end
            if (k % 10 == 9) wait_idle();
        end

        repeat (260) err_hdr({1'($urandom), 7'($urandom_range(1, 127)), 8'($urandom)});
        wait_idle();
        chk("err_saturated", err_count, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
